// File: rtl/mips_pkg.sv
// Shared widths, fetch-state encoding and PC helper for the instruction-fetch stage.
package mips_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
   } fetch_word_t;

   // Sequential PC, wrapping modulo 2^32.
   function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: flush has priority over load; otherwise contents hold.
module if_id_pipe_reg
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              load,
   input  logic [WORD_W-1:0] d_instr,
   input  logic [WORD_W-1:0] d_pc,
   input  logic              d_valid,
   output logic [WORD_W-1:0] q_instr,
   output logic [WORD_W-1:0] q_pc,
   output logic              q_valid
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_instr <= NOP_WORD;
         q_pc    <= '0;
         q_valid <= 1'b0;
      end else if (flush) begin
         q_instr <= NOP_WORD;
         q_pc    <= '0;
         q_valid <= 1'b0;
      end else if (load) begin
         q_instr <= d_instr;
         q_pc    <= d_pc;
         q_valid <= d_valid;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: req/ack fetch FSM, PC, wrong-path squash and a one-word
// hold buffer that parks a fetched instruction while ID is frozen.
module if_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   input  logic        branch_taken,
   input  logic [31:0] branch_address,
   input  logic        freeze,
   output logic [31:0] if_id_instruction,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid
);

   fetch_state_t state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic         squash_reg, squash_next;
   logic [31:0]  squash_addr_reg, squash_addr_next;
   fetch_word_t  hold_reg, hold_next;
   logic         active_reg;
   logic         accept;

   logic         pipe_flush, pipe_load, pipe_valid;
   logic [31:0]  pipe_instr, pipe_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= S_FETCH;
         pc_reg          <= RESET_PC;
         squash_reg      <= 1'b0;
         squash_addr_reg <= '0;
         hold_reg        <= '0;
         active_reg      <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         squash_reg      <= squash_next;
         squash_addr_reg <= squash_addr_next;
         hold_reg        <= hold_next;
         active_reg      <= 1'b1;
      end
   end

   // A squashed request keeps presenting its original address until it completes.
   assign imem_req  = active_reg && (state_reg == S_FETCH);
   assign imem_addr = squash_reg ? squash_addr_reg : pc_reg;
   assign accept    = imem_req && imem_ack;

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      squash_next      = squash_reg;
      squash_addr_next = squash_addr_reg;
      hold_next        = hold_reg;
      if (branch_taken) begin
         pc_next          = branch_address;
         hold_next        = '0;
         state_next       = S_FETCH;
         squash_next      = imem_req && !imem_ack;
         squash_addr_next = imem_addr;
      end else begin
         case (state_reg)
            S_FETCH: begin
               if (accept) begin
                  if (squash_reg) begin
                     squash_next = 1'b0;
                  end else begin
                     pc_next = next_pc(pc_reg);
                     if (freeze) begin
                        hold_next  = '{instr: imem_rdata, pc: next_pc(pc_reg)};
                        state_next = S_HOLD;
                     end
                  end
               end
            end
            S_HOLD: begin
               if (!freeze) state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
         endcase
      end
   end

   always_comb begin
      pipe_flush = branch_taken;
      pipe_load  = 1'b0;
      pipe_instr = NOP_INSTR;
      pipe_pc    = if_id_pc;
      pipe_valid = 1'b0;
      if (!branch_taken && !freeze) begin
         pipe_load = 1'b1;
         if (state_reg == S_HOLD) begin
            pipe_instr = hold_reg.instr;
            pipe_pc    = hold_reg.pc;
            pipe_valid = 1'b1;
         end else if (accept && !squash_reg) begin
            pipe_instr = imem_rdata;
            pipe_pc    = next_pc(pc_reg);
            pipe_valid = 1'b1;
         end
      end
   end

   if_id_pipe_reg #(
      .NOP_WORD (NOP_INSTR)
   ) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .flush   (pipe_flush),
      .load    (pipe_load),
      .d_instr (pipe_instr),
      .d_pc    (pipe_pc),
      .d_valid (pipe_valid),
      .q_instr (if_id_instruction),
      .q_pc    (if_id_pc),
      .q_valid (if_id_valid)
   );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a configurable-wait instruction memory.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_address = '0;
   logic        freeze = 1'b0;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_pc;
   logic        if_id_valid;

   int   checks = 0;
   int   errors = 0;
   int   mem_wait = 0;
   int   wait_cnt;
   logic force_ack = 1'b0;

   always #5 clk = ~clk;

   // Memory: ack once the request has waited mem_wait cycles; word = 0xC000_0000 | addr.
   always @(posedge clk or negedge rst) begin
      if (!rst) wait_cnt <= 0;
      else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end
   assign imem_ack   = force_ack | (imem_req && (wait_cnt >= mem_wait));
   assign imem_rdata = imem_req ? (32'hC000_0000 | imem_addr) : 32'hBAD0_BAD0;

   if_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_rdata        (imem_rdata),
      .imem_ack          (imem_ack),
      .branch_taken      (branch_taken),
      .branch_address    (branch_address),
      .freeze            (freeze),
      .if_id_instruction (if_id_instruction),
      .if_id_pc          (if_id_pc),
      .if_id_valid       (if_id_valid)
   );

   // Leaves rst released just after a falling edge; the next falling edge shows the first request.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      branch_taken = 1'b0;
      freeze = 1'b0;
      force_ack = 1'b0;
      mem_wait = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [64:0] got, exp;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b0, 32'h0, 32'h0};
      if (got !== exp || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got req=%b ifid=%h exp req=0 ifid=%h", imem_req, got, exp);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_req got %b exp 0", imem_req);
      end
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL first_req got req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr);
      end
      $display("test_reset done");
   endtask

   task automatic test_stream();
      logic [64:0] got, exp;
      do_reset();
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({imem_req, imem_addr} !== {1'b1, 32'(4 * k)}) begin
            errors++;
            $display("FAIL stream_addr k=%0d got req=%b addr=%h exp addr=%h", k, imem_req, imem_addr, 32'(4 * k));
         end
         if (k > 0) begin
            checks++;
            got = {if_id_valid, if_id_pc, if_id_instruction};
            exp = {1'b1, 32'(4 * k), 32'hC000_0000 + 32'(4 * (k - 1))};
            if (got !== exp) begin
               errors++;
               $display("FAIL stream_ifid k=%0d got %h exp %h", k, got, exp);
            end
         end
         @(negedge clk);
      end
      $display("test_stream done");
   endtask

   task automatic test_latency();
      logic [64:0] got, exp;
      logic        exp_valid;
      do_reset();
      mem_wait = 2;
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if ({imem_req, imem_addr} !== {1'b1, 32'(4 * (i / 3))}) begin
            errors++;
            $display("FAIL latency_addr i=%0d got req=%b addr=%h exp addr=%h", i, imem_req, imem_addr, 32'(4 * (i / 3)));
         end
         exp_valid = (i >= 3) && (i % 3 == 0);
         checks++;
         if (if_id_valid !== exp_valid) begin
            errors++;
            $display("FAIL latency_valid i=%0d got %b exp %b", i, if_id_valid, exp_valid);
         end
         if (exp_valid) begin
            checks++;
            got = {if_id_valid, if_id_pc, if_id_instruction};
            exp = {1'b1, 32'(4 * (i / 3)), 32'hC000_0000 + 32'(4 * (i / 3 - 1))};
            if (got !== exp) begin
               errors++;
               $display("FAIL latency_ifid i=%0d got %h exp %h", i, got, exp);
            end
         end
         @(negedge clk);
      end
      $display("test_latency done");
   endtask

   task automatic test_freeze();
      logic [64:0] got, exp;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      freeze = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         checks++;
         got = {if_id_valid, if_id_pc, if_id_instruction};
         exp = {1'b1, 32'h4, 32'hC000_0000};
         if (got !== exp || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold j=%0d got req=%b ifid=%h exp req=0 ifid=%h", j, imem_req, got, exp);
         end
      end
      freeze = 1'b0;
      @(negedge clk);
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b1, 32'h8, 32'hC000_0004};
      if (got !== exp || {imem_req, imem_addr} !== {1'b1, 32'h8}) begin
         errors++;
         $display("FAIL freeze_release got req=%b addr=%h ifid=%h exp req=1 addr=8 ifid=%h", imem_req, imem_addr, got, exp);
      end
      @(negedge clk);
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b1, 32'hC, 32'hC000_0008};
      if (got !== exp || imem_addr !== 32'hC) begin
         errors++;
         $display("FAIL freeze_resume got addr=%h ifid=%h exp addr=c ifid=%h", imem_addr, got, exp);
      end
      $display("test_freeze done");
   endtask

   task automatic test_branch_squash();
      logic [64:0] got, exp;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      mem_wait = 3;
      checks++;
      if (imem_addr !== 32'h8) begin
         errors++;
         $display("FAIL squash_pre_addr got %h exp 00000008", imem_addr);
      end
      branch_taken = 1'b1;
      branch_address = 32'h100;
      @(negedge clk);
      branch_taken = 1'b0;
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b0, 32'h0, 32'h0};
      if (got !== exp) begin
         errors++;
         $display("FAIL squash_flush got %h exp %h", got, exp);
      end
      for (int j = 0; j < 3; j++) begin
         checks++;
         if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL squash_old_addr j=%0d got req=%b addr=%h exp req=1 addr=8", j, imem_req, imem_addr);
         end
         @(negedge clk);
      end
      checks++;
      if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h100, 1'b0}) begin
         errors++;
         $display("FAIL squash_target got req=%b addr=%h valid=%b exp req=1 addr=100 valid=0", imem_req, imem_addr, if_id_valid);
      end
      mem_wait = 0;
      @(negedge clk);
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b1, 32'h104, 32'hC000_0100};
      if (got !== exp || imem_addr !== 32'h104) begin
         errors++;
         $display("FAIL squash_after got addr=%h ifid=%h exp addr=104 ifid=%h", imem_addr, got, exp);
      end
      $display("test_branch_squash done");
   endtask

   task automatic test_branch_hold();
      logic [64:0] got, exp;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      freeze = 1'b1;
      @(negedge clk);
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b1, 32'h4, 32'hC000_0000};
      if (got !== exp || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL bhold_pre got req=%b ifid=%h exp req=0 ifid=%h", imem_req, got, exp);
      end
      branch_taken = 1'b1;
      branch_address = 32'h200;
      @(negedge clk);
      branch_taken = 1'b0;
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b0, 32'h0, 32'h0};
      if (got !== exp || {imem_req, imem_addr} !== {1'b1, 32'h200}) begin
         errors++;
         $display("FAIL bhold_flush got req=%b addr=%h ifid=%h exp req=1 addr=200 ifid=%h", imem_req, imem_addr, got, exp);
      end
      freeze = 1'b0;
      @(negedge clk);
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b1, 32'h204, 32'hC000_0200};
      if (got !== exp) begin
         errors++;
         $display("FAIL bhold_after got %h exp %h", got, exp);
      end
      $display("test_branch_hold done");
   endtask

   task automatic test_reset_mid();
      logic [64:0] got, exp;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b1, 32'h8, 32'hC000_0004};
      if (got !== exp || imem_addr !== 32'h8) begin
         errors++;
         $display("FAIL rmid_pre got addr=%h ifid=%h exp addr=8 ifid=%h", imem_addr, got, exp);
      end
      mem_wait = 5;
      rst = 1'b0;
      #1;
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b0, 32'h0, 32'h0};
      if (got !== exp || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rmid_async got req=%b ifid=%h exp req=0 ifid=%h", imem_req, got, exp);
      end
      @(negedge clk);
      rst = 1'b1;
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b0, 32'h0, 32'h0};
      if (got !== exp || {imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL rmid_stray_ack got req=%b addr=%h ifid=%h exp req=1 addr=0 ifid=%h", imem_req, imem_addr, got, exp);
      end
      mem_wait = 0;
      @(negedge clk);
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b1, 32'h4, 32'hC000_0000};
      if (got !== exp) begin
         errors++;
         $display("FAIL rmid_refetch got %h exp %h", got, exp);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_wrap();
      logic [64:0] got, exp;
      do_reset();
      @(negedge clk);
      branch_taken = 1'b1;
      branch_address = 32'hFFFF_FFFC;
      @(negedge clk);
      branch_taken = 1'b0;
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b0, 32'h0, 32'h0};
      if (got !== exp || {imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         errors++;
         $display("FAIL wrap_ack_branch got req=%b addr=%h ifid=%h exp req=1 addr=fffffffc ifid=%h", imem_req, imem_addr, got, exp);
      end
      @(negedge clk);
      checks++;
      got = {if_id_valid, if_id_pc, if_id_instruction};
      exp = {1'b1, 32'h0, 32'hFFFF_FFFC};
      if (got !== exp || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_pc got addr=%h ifid=%h exp addr=0 ifid=%h", imem_addr, got, exp);
      end
      $display("test_wrap done");
   endtask

   initial begin
      test_reset();
      test_stream();
      test_latency();
      test_freeze();
      test_branch_squash();
      test_branch_hold();
      test_reset_mid();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
